// File: rtl/nfa_pkg.sv
// Shared helpers for the parametrised NFA chain engine.
// Class-field extraction, saturating increment, class width.
package nfa_pkg;

  localparam int MAX_SC_W = 1024;

  function automatic int class_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned class_idx(
    input logic [MAX_SC_W-1:0] sc,
    input int                  i,
    input int                  w
  );
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return int'(32'(sc >> (i * w)) & mask);
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] top
  );
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/nfa_chain_engine_cell.sv
// One NFA state bit: class hit gated by predecessor,
// self-loop or dot-star bypass; clr drops the self-loop.
module nfa_state_cell (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  input  logic hit,
  input  logic prev,
  input  logic loop,
  input  logic byp,
  output logic nxt,
  output logic q
);

  // next value of this state for the current byte
  always_comb begin
    nxt = hit & (prev | (loop & q & ~clr) | byp);
  end

  // state bit advances only on valid bytes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  q <= 1'b0;
    else if (en)  q <= nxt;
  end

endmodule

// File: rtl/nfa_chain_engine.sv
// Generic NFA chain with per-packet match count,
// first-match offset and a valid/ready result port.
module nfa_chain_engine #(
  parameter int N_STATES  = 18,
  parameter int N_CLASSES = 64,
  parameter int CLASS_W   = 6,
  parameter logic [N_STATES*CLASS_W-1:0] STATE_CLASS = '0,
  parameter logic [N_STATES-1:0] LOOP_MASK = '0,
  parameter int ANCHORED  = 0,
  parameter int OFF_W     = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic                 sod,
  input  logic                 eod,
  input  logic [N_CLASSES-1:0] in_class,
  output logic                 match,
  output logic                 match_pulse,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_match,
  output logic [OFF_W-1:0]     res_off,
  output logic [CNT_W-1:0]     res_cnt,
  output logic                 res_drop
);
  import nfa_pkg::*;

  localparam logic [MAX_SC_W-1:0] SC =
    MAX_SC_W'(STATE_CLASS);
  localparam logic [31:0] OFF_MAX =
    32'((64'd1 << OFF_W) - 64'd1);
  localparam logic [31:0] CNT_MAX =
    32'((64'd1 << CNT_W) - 64'd1);

  if (CLASS_W < class_bits(N_CLASSES)) begin : g_bad_cw
    $error("CLASS_W too narrow for N_CLASSES");
  end

  logic [N_STATES-1:0] s, p, prv, byp, hit, nxt;
  logic start, done, base_m, match_n, cap;
  logic [OFF_W-1:0] off, cur_off, first_off, fo_n;
  logic [CNT_W-1:0] cnt, cur_cnt, cnt_n;
  logic unused;

  assign p     = sod ? '0 : s;
  assign start = (ANCHORED == 0) ? 1'b1 : sod;

  for (genvar i = 0; i < N_STATES; i++) begin : g_st
    localparam int CI = int'(class_idx(SC, i, CLASS_W));
    assign hit[i] = in_class[CI];
    if (i == 0) begin : g_first
      assign prv[i] = start;
      assign byp[i] = 1'b0;
    end else if (i == 1) begin : g_second
      assign prv[i] = p[0];
      assign byp[i] = LOOP_MASK[0] & start;
    end else begin : g_rest
      assign prv[i] = p[i-1];
      assign byp[i] = LOOP_MASK[i-1] & p[i-2];
    end
    nfa_state_cell u_cell (
      .clk    (clk),
      .resetn (resetn),
      .en     (en),
      .clr    (sod),
      .hit    (hit[i]),
      .prev   (prv[i]),
      .loop   (LOOP_MASK[i]),
      .byp    (byp[i]),
      .nxt    (nxt[i]),
      .q      (s[i])
    );
  end

  assign unused = ^{in_class, p, s};

  // per-byte packet bookkeeping seen by this byte
  always_comb begin
    done    = en & nxt[N_STATES-1];
    cur_off = sod ? '0 : off;
    cur_cnt = sod ? '0 : cnt;
    base_m  = ~sod & match;
    match_n = base_m | done;
    cnt_n   = done
      ? CNT_W'(sat_inc(32'(cur_cnt), CNT_MAX))
      : cur_cnt;
    fo_n    = (done & ~base_m) ? cur_off : first_off;
    cap     = en & eod;
  end

  // offset, count, sticky match and first offset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      off         <= '0;
      cnt         <= '0;
      match       <= 1'b0;
      first_off   <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= done;
      if (en) begin
        off       <= OFF_W'(sat_inc(32'(cur_off), OFF_MAX));
        cnt       <= cnt_n;
        match     <= match_n;
        first_off <= fo_n;
      end
    end
  end

  // result register with valid/ready and drop-on-collision
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_off   <= '0;
      res_cnt   <= '0;
      res_drop  <= 1'b0;
    end else begin
      res_drop <= 1'b0;
      if (cap && res_valid && !res_ready) begin
        res_drop <= 1'b1;
      end else if (cap) begin
        res_valid <= 1'b1;
        res_match <= match_n;
        res_off   <= match_n ? fo_n : '0;
        res_cnt   <= cnt_n;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nfa_chain_engine.sv
// Bench for nfa_chain_engine: pattern ab.*cd on three
// instances (unanchored, anchored, 2-bit counter).
module tb_nfa_chain_engine;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0, sod = 1'b0, eod = 1'b0;
  logic res_ready = 1'b0;
  logic [7:0] in_class = '0;

  logic mt[3], mp[3], rv[3], rm[3], rd[3];
  logic [15:0] ro[3];
  logic [7:0] rc[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 8;
    logic [CW-1:0] rcl;
    nfa_chain_engine #(
      .N_STATES    (5),
      .N_CLASSES   (8),
      .CLASS_W     (3),
      .STATE_CLASS (15'b100_011_010_001_000),
      .LOOP_MASK   (5'b00100),
      .ANCHORED    ((g == 1) ? 1 : 0),
      .OFF_W       (16),
      .CNT_W       (CW)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .en          (en),
      .sod         (sod),
      .eod         (eod),
      .in_class    (in_class),
      .match       (mt[g]),
      .match_pulse (mp[g]),
      .res_valid   (rv[g]),
      .res_ready   (res_ready),
      .res_match   (rm[g]),
      .res_off     (ro[g]),
      .res_cnt     (rcl),
      .res_drop    (rd[g])
    );
    assign rc[g] = 8'(rcl);
  end

  int n_chk = 0, n_fail = 0;

  byte hist[$];
  bit  seg_sod;
  bit  e_m[3], e_p[3], e_v[3], e_rm[3], e_d[3];
  int  e_c[3], e_f[3], e_ro[3], e_rc[3];
  int  pc[3], pi[3];

  function automatic int cmax(input int d);
    return (d == 2) ? 3 : 255;
  endfunction

  function automatic logic [7:0] cls(input byte ch);
    case (ch)
      "a": return 8'h05;
      "b": return 8'h06;
      "c": return 8'h0c;
      "d": return 8'h14;
      default: return 8'h04;
    endcase
  endfunction

  // does the newest byte complete ab.*cd in this segment?
  function automatic bit done_at(input bit anch);
    int j = hist.size() - 1;
    if (j < 3) return 0;
    if (hist[j] != "d" || hist[j-1] != "c") return 0;
    for (int k = 0; k + 3 <= j; k++) begin
      if (anch && (k != 0 || !seg_sod)) continue;
      if (hist[k] == "a" && hist[k+1] == "b") return 1;
    end
    return 0;
  endfunction

  task automatic model_clear();
    hist.delete();
    seg_sod = 0;
    for (int d = 0; d < 3; d++) begin
      e_m[d] = 0; e_p[d] = 0; e_v[d] = 0; e_rm[d] = 0;
      e_d[d] = 0; e_c[d] = 0; e_f[d] = 0; e_ro[d] = 0;
      e_rc[d] = 0;
    end
  endtask

  task automatic cyc(input bit e, input bit s, input bit eo,
                     input byte ch, input bit rdy);
    int o;
    en = e; sod = s; eod = eo;
    in_class = cls(ch); res_ready = rdy;
    for (int d = 0; d < 3; d++) begin
      e_p[d] = 0; e_d[d] = 0;
    end
    if (e) begin
      if (s) begin hist.delete(); seg_sod = 1; end
      hist.push_back(ch);
      o = hist.size() - 1;
      if (o > 65535) o = 65535;
      for (int d = 0; d < 3; d++) begin
        bit dn, bm;
        int bc;
        dn = done_at(d == 1);
        bm = !s && e_m[d];
        if (dn && !bm) e_f[d] = o;
        e_m[d] = bm || dn;
        bc = s ? 0 : e_c[d];
        if (dn && bc < cmax(d)) bc++;
        e_c[d] = bc;
        e_p[d] = dn;
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (e && eo) begin
        if (e_v[d] && !rdy) e_d[d] = 1;
        else begin
          e_v[d] = 1; e_rm[d] = e_m[d];
          e_ro[d] = e_m[d] ? e_f[d] : 0;
          e_rc[d] = e_c[d];
        end
      end else if (e_v[d] && rdy) e_v[d] = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input string str, input bit rdy);
    for (int d = 0; d < 3; d++) begin pc[d] = 0; pi[d] = -1; end
    for (int i = 0; i < str.len(); i++) begin
      cyc(1, i == 0, i == str.len() - 1, str[i], rdy);
      for (int d = 0; d < 3; d++)
        if (mp[d]) begin pc[d]++; pi[d] = i; end
    end
  endtask

  task automatic do_reset();
    en = 0; sod = 0; eod = 0; res_ready = 0; in_class = '0;
    resetn = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({mt[d], mp[d], rv[d], rd[d], rm[d], ro[d], rc[d]}
          !== 28'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b%b%b%b%b %0d %0d want 0",
                 d, mt[d], mp[d], rv[d], rd[d], rm[d], ro[d], rc[d]);
      end
    end
  endtask

  task automatic test_basic();
    send("xabqqcd", 1);
    n_chk++;
    if (pc[0] !== 1 || pi[0] !== 6) begin
      n_fail++;
      $display("FAIL basic_pulse: got n=%0d at %0d want 1 at 6",
               pc[0], pi[0]);
    end
    n_chk++;
    if ({rv[0], rm[0]} !== 2'b11 || ro[0] !== 16'd6 ||
        rc[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_res: got v%b m%b off=%0d cnt=%0d want 1 1 6 1",
               rv[0], rm[0], ro[0], rc[0]);
    end
  endtask

  task automatic test_bypass();
    send("abcd", 1);
    n_chk++;
    if (rm[0] !== 1'b1 || ro[0] !== 16'd3 || rc[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL bypass_abcd: got m%b off=%0d cnt=%0d want 1 3 1",
               rm[0], ro[0], rc[0]);
    end
    send("abcdcd", 1);
    n_chk++;
    if (pc[0] !== 2 || rc[0] !== 8'd2 || ro[0] !== 16'd3) begin
      n_fail++;
      $display("FAIL bypass_abcdcd: got pulses=%0d cnt=%0d off=%0d want 2 2 3",
               pc[0], rc[0], ro[0]);
    end
  endtask

  task automatic test_anchored();
    send("xabcd", 1);
    n_chk++;
    if (pc[1] !== 0 || rm[1] !== 1'b0 || ro[1] !== 16'd0 ||
        rc[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL anch_x: got p=%0d m%b off=%0d cnt=%0d want 0 0 0 0",
               pc[1], rm[1], ro[1], rc[1]);
    end
    n_chk++;
    if (rm[0] !== 1'b1 || ro[0] !== 16'd4) begin
      n_fail++;
      $display("FAIL unanch_x: got m%b off=%0d want 1 4", rm[0], ro[0]);
    end
    send("abcd", 1);
    n_chk++;
    if (rm[1] !== 1'b1 || ro[1] !== 16'd3) begin
      n_fail++;
      $display("FAIL anch_abcd: got m%b off=%0d want 1 3", rm[1], ro[1]);
    end
  endtask

  task automatic test_backpressure();
    cyc(0, 0, 0, "x", 1);
    send("abcd", 0);
    n_chk++;
    if (rv[0] !== 1'b1 || rm[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: got v%b m%b want 1 1", rv[0], rm[0]);
    end
    send("zz", 0);
    n_chk++;
    if (rd[0] !== 1'b1 || rm[0] !== 1'b1 || rc[0] !== 8'd1 ||
        ro[0] !== 16'd3) begin
      n_fail++;
      $display("FAIL bp_drop: got drop%b m%b cnt=%0d off=%0d want 1 1 1 3",
               rd[0], rm[0], rc[0], ro[0]);
    end
    cyc(0, 0, 0, "x", 1);
    n_chk++;
    if (rv[0] !== 1'b0 || rd[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got v%b drop%b want 0 0", rv[0], rd[0]);
    end
  endtask

  task automatic test_en_gaps();
    cyc(1, 1, 0, "a", 1);
    cyc(1, 0, 0, "b", 1);
    repeat (3) cyc(0, 1, 1, "c", 1);
    n_chk++;
    if (mt[0] !== 1'b0 || rv[0] !== 1'b0 || mp[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_hold: got m%b v%b p%b want 0 0 0",
               mt[0], rv[0], mp[0]);
    end
    cyc(1, 0, 0, "x", 1);
    cyc(1, 0, 0, "x", 1);
    cyc(1, 0, 0, "c", 1);
    cyc(1, 0, 1, "d", 1);
    n_chk++;
    if (rm[0] !== 1'b1 || ro[0] !== 16'd5 || rc[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL gap_res: got m%b off=%0d cnt=%0d want 1 5 1",
               rm[0], ro[0], rc[0]);
    end
    send("abcdcdcdcd", 1);
    n_chk++;
    if (rc[2] !== 8'd3 || rc[0] !== 8'd4 || ro[2] !== 16'd3) begin
      n_fail++;
      $display("FAIL sat_cnt: got c2=%0d c0=%0d off=%0d want 3 4 3",
               rc[2], rc[0], ro[2]);
    end
  endtask

  task automatic test_reset_mid();
    send("abcd", 0);
    cyc(1, 1, 0, "a", 0);
    cyc(1, 0, 0, "b", 0);
    cyc(1, 0, 0, "c", 0);
    resetn = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({mt[d], mp[d], rv[d], rd[d], rm[d], ro[d], rc[d]}
          !== 28'd0) begin
        n_fail++;
        $display("FAIL async_rst[%0d]: got v%b m%b off=%0d want 0",
                 d, rv[d], mt[d], ro[d]);
      end
    end
    model_clear();
    #1 resetn = 1;
    @(posedge clk); #1;
    cyc(1, 0, 1, "d", 1);
    n_chk++;
    if (mp[0] !== 1'b0 || rv[0] !== 1'b1 || rm[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_d: got p%b v%b m%b want 0 1 0",
               mp[0], rv[0], rm[0]);
    end
    send("abcd", 1);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (rm[d] !== 1'b1 || ro[d] !== 16'd3) begin
        n_fail++;
        $display("FAIL rst_abcd[%0d]: got m%b off=%0d want 1 3",
                 d, rm[d], ro[d]);
      end
    end
  endtask

  task automatic test_random();
    string alpha = "abcdx";
    int pos = 0, len = 1;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit e;
      byte ch;
      e = ($urandom_range(3) != 0);
      ch = alpha[$urandom_range(4)];
      if (e && pos == 0) len = $urandom_range(10, 1);
      cyc(e, e && pos == 0, e && pos == len - 1, ch,
          bit'($urandom_range(1)));
      if (e) pos = (pos == len - 1) ? 0 : pos + 1;
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (mt[d] !== e_m[d] || mp[d] !== e_p[d] ||
            rv[d] !== e_v[d] || rd[d] !== e_d[d]) begin
          n_fail++;
          $display("FAIL rnd_ctl[%0d] n=%0d: got %b%b%b%b want %b%b%b%b",
                   d, n, mt[d], mp[d], rv[d], rd[d],
                   e_m[d], e_p[d], e_v[d], e_d[d]);
        end
        if (e_v[d]) begin
          n_chk++;
          if (rm[d] !== e_rm[d] || ro[d] !== 16'(e_ro[d]) ||
              rc[d] !== 8'(e_rc[d])) begin
            n_fail++;
            $display("FAIL rnd_res[%0d] n=%0d: got m%b %0d %0d want m%b %0d %0d",
                     d, n, rm[d], ro[d], rc[d],
                     e_rm[d], e_ro[d], e_rc[d]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_anchored();
    test_backpressure();
    test_en_gaps();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
